frame_parser_param: RTL
=======================

Name: frame_parser_param

Overview:
Parametrised, streaming frame parser for the chaoslogic ingress path, placed between the serial word input and the channel FIFO.
- Frame format: HDR_WORD, HDR_WORD, channel word, 1..MAX_WORDS payload words, CRC word, TAIL_WORD, TAIL_WORD.
- Computes CRC-16 internally and on the fly, with no external CRC block.
- Checks length and CRC, then presents each good frame through a one-entry valid/ready output buffer.
- Reports CRC, length and overflow errors as single-cycle pulses, and keeps running frame statistics.

Parameters:
- DW, 16, word width in bits. Must be ≥ CH_W and ≥ 16.
- MAX_WORDS, 8, maximum payload words per frame.
- CH_W, 8, channel field width, taken from the low bits of the channel word.
- HDR_WORD, 16'hE0E0, header word, zero-extended to DW.
- TAIL_WORD, 16'h0E0E, tail word, zero-extended to DW. Reserved: never valid as payload.
- CRC_POLY, 16'h1021, CRC-16 polynomial.
- CRC_INIT, 16'hFFFF, CRC seed.
- LEN_W, $clog2(MAX_WORDS+1), width of the length field.

Ports:
- clk_in  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  data_in carries a word this cycle
- data_in  input  DW  input word
- out_valid  output  1  output buffer holds a good frame
- out_ready  input  1  consumer accepts the frame
- out_data  output  MAX_WORDS*DW  payload; word k at [k*DW +: DW]; unused words zero
- out_ch  output  CH_W  channel field
- out_len  output  LEN_W  payload word count, 1..MAX_WORDS
- crc_err  output  1  pulse: CRC mismatch
- len_err  output  1  pulse: zero-length or over-length frame
- ovf_err  output  1  pulse: good frame dropped because the buffer was full
- frame_cnt  output  16  good frames accepted into the buffer; wraps
- err_cnt  output  16  crc_err + len_err + ovf_err events; wraps

Behaviour:
- Reset values:
  - All outputs 0; internal CRC = CRC_INIT; FSM in IDLE.
  - Reset mid-frame discards the frame and any buffered frame.
- Word consumption:
  - Words are consumed only when in_valid=1; every state holds when in_valid=0.
  - All comparisons below refer to consumed words.
- FSM:
  - IDLE: HDR → HDR2.
  - HDR2: HDR → CHAN; else → IDLE.
  - CHAN: latch data_in[CH_W-1:0]; clear the word count, pending-valid flag and payload store; CRC = CRC_INIT. → DATA.
  - DATA: word == TAIL → TAIL2, with count = words received before TAIL; otherwise store the word.
  - TAIL2: TAIL → CHECK; else → IDLE silently (no error pulse).
  - CHECK: one cycle with no word consumed. Compare the computed CRC with the pending word, update counters and buffer. → IDLE.
- Delayed CRC update in DATA:
  - On each stored word, if pending-valid: crc <= step(crc, pending). Then pending <= word, pending-valid <= 1.
  - At tail time the pending word is the frame's CRC field. crc covers exactly payload words 0..count-2.
  - step(): MSB-first bitwise CRC, DW bits per word, no reflection, no final XOR, CRC-16/CCITT-FALSE style. Fully combinational, one word per cycle.
- Payload storage: the word is written at index count-1 once its successor arrives, i.e. the payload excludes the CRC word.
- Length rules:
  - payload length L = count-1.
  - count ≤ 1 at TAIL (L=0): pulse len_err, → IDLE.
  - A word arriving in DATA when count == MAX_WORDS+1 (the current word is not TAIL): pulse len_err, → IDLE.
- CHECK outcomes:
  - CRC mismatch: pulse crc_err.
  - CRC match and buffer empty, or the buffer being emptied this same cycle (out_valid & out_ready): load out_data/out_ch/out_len, set out_valid next cycle, frame_cnt += 1.
  - CRC match and buffer full, not being emptied: pulse ovf_err; frame dropped; buffer unchanged.
- Latency: out_valid rises 2 cycles after the clock edge that consumes the second TAIL.
- Output handshake:
  - out_data, out_ch and out_len stay stable while out_valid=1.
  - out_valid clears the cycle after out_valid & out_ready unless refilled that same cycle.
- Error counter: err_cnt increments by 1 per error pulse. At most one error pulse per cycle.
- Resync: a HDR seen in DATA is treated as payload. There is no mid-frame resync; recovery happens via the length limit.

Test Plan:
1. Good frame: E0E0,E0E0,0x0003, payload 0x1111,0x2222,0x3333, CRC = golden CRC-16/CCITT-FALSE(0x1111,0x2222,0x3333), 0E0E,0E0E → out_valid 2 cycles after the last tail; out_ch=0x03, out_len=3; out_data[47:0]=0x3333_2222_1111, upper bits 0; frame_cnt=1.
2. Same frame with CRC field XOR 0x0001 → crc_err single pulse, no out_valid, err_cnt=1.
3. Length errors:
   - Header, channel, then CRC word immediately followed by tail (L=0) → len_err.
   - MAX_WORDS+2 non-tail words after the channel word → len_err on word MAX_WORDS+2, FSM returns to IDLE. A following good frame parses correctly.
4. Backpressure: out_ready=0, send two good frames → the first is held stable, the second gives ovf_err, frame_cnt=1. Raise out_ready in the same cycle as the second frame's CHECK → the second frame is accepted, no ovf_err.
5. in_valid gaps: the test 1 frame with in_valid toggling 1-0-1 on every word → identical output to test 1. Also apply rst mid-payload → all outputs 0 and the next frame is accepted.
6. Non-default parameters DW=32, MAX_WORDS=4, CH_W=12: 4-word payload → out_len=4, correct packing and CRC. E0E0,1234 → back to IDLE with no error pulse.

Source files
------------

// File: rtl/frame_parser_param.sv
// Streaming frame parser: header/channel/payload/CRC/tail framing with an on-the-fly
// CRC-16 check, length limits, a one-entry valid/ready output buffer and statistics.
module frame_parser_param #(
   parameter int unsigned DW        = 16,
   parameter int unsigned MAX_WORDS = 8,
   parameter int unsigned CH_W      = 8,
   parameter logic [15:0] HDR_WORD  = 16'hE0E0,
   parameter logic [15:0] TAIL_WORD = 16'h0E0E,
   parameter logic [15:0] CRC_POLY  = 16'h1021,
   parameter logic [15:0] CRC_INIT  = 16'hFFFF,
   parameter int unsigned LEN_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [DW-1:0]           data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [MAX_WORDS*DW-1:0] out_data,
   output logic [CH_W-1:0]         out_ch,
   output logic [LEN_W-1:0]        out_len,
   output logic                    crc_err,
   output logic                    len_err,
   output logic                    ovf_err,
   output logic [15:0]             frame_cnt,
   output logic [15:0]             err_cnt
);

   localparam int unsigned   CNT_W = $clog2(MAX_WORDS + 2);
   localparam logic [DW-1:0] HDR   = DW'(HDR_WORD);
   localparam logic [DW-1:0] TAIL  = DW'(TAIL_WORD);

   typedef enum logic [2:0] {S_IDLE, S_HDR2, S_CHAN, S_DATA, S_TAIL2, S_CHECK} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        count;
   logic [15:0]             crc;
   logic [DW-1:0]           pend;
   logic                    pend_vld;
   logic [MAX_WORDS*DW-1:0] store;
   logic [CH_W-1:0]         ch_q;
   logic [LEN_W-1:0]        len_q;
   logic                    ld_q;

   // MSB-first CRC-16 over one full word, no reflection, no final XOR
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] w);
      logic [15:0]   r;
      logic [DW-1:0] d;
      r = c;
      d = w;
      for (int i = 0; i < int'(DW); i++) begin
         if (r[15] ^ d[DW-1]) r = {r[14:0], 1'b0} ^ CRC_POLY;
         else                 r = {r[14:0], 1'b0};
         d = d << 1;
      end
      return r;
   endfunction

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         crc       <= CRC_INIT;
         pend      <= '0;
         pend_vld  <= 1'b0;
         store     <= '0;
         ch_q      <= '0;
         len_q     <= '0;
         ld_q      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_len   <= '0;
         crc_err   <= 1'b0;
         len_err   <= 1'b0;
         ovf_err   <= 1'b0;
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         crc_err <= 1'b0;
         len_err <= 1'b0;
         ovf_err <= 1'b0;
         ld_q    <= 1'b0;

         if (out_valid && out_ready) out_valid <= 1'b0;

         // Accepted frame lands in the buffer the cycle after CHECK
         if (ld_q) begin
            out_valid <= 1'b1;
            out_data  <= store;
            out_ch    <= ch_q;
            out_len   <= len_q;
            frame_cnt <= frame_cnt + 16'd1;
         end

         case (state)
            S_IDLE: begin
               if (in_valid && (data_in == HDR)) state <= S_HDR2;
            end
            S_HDR2: begin
               if (in_valid) state <= (data_in == HDR) ? S_CHAN : S_IDLE;
            end
            S_CHAN: begin
               if (in_valid) begin
                  ch_q     <= data_in[CH_W-1:0];
                  count    <= '0;
                  pend_vld <= 1'b0;
                  store    <= '0;
                  crc      <= CRC_INIT;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (in_valid) begin
                  if (data_in == TAIL) begin
                     if (count <= CNT_W'(1)) begin
                        len_err <= 1'b1;
                        err_cnt <= err_cnt + 16'd1;
                        state   <= S_IDLE;
                     end else begin
                        len_q <= LEN_W'(count - CNT_W'(1));
                        state <= S_TAIL2;
                     end
                  end else if (count == CNT_W'(MAX_WORDS + 1)) begin
                     len_err <= 1'b1;
                     err_cnt <= err_cnt + 16'd1;
                     state   <= S_IDLE;
                  end else begin
                     // The newest word is held back: at the tail it is the CRC field
                     if (pend_vld) begin
                        crc <= crc_step(crc, pend);
                        for (int k = 0; k < int'(MAX_WORDS); k++) begin
                           if (count == CNT_W'(k + 1)) store[k*DW +: DW] <= pend;
                        end
                     end
                     pend     <= data_in;
                     pend_vld <= 1'b1;
                     count    <= count + CNT_W'(1);
                  end
               end
            end
            S_TAIL2: begin
               if (in_valid) state <= (data_in == TAIL) ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
               if (pend != DW'(crc)) begin
                  crc_err <= 1'b1;
                  err_cnt <= err_cnt + 16'd1;
               end else if (!out_valid || out_ready) begin
                  ld_q <= 1'b1;
               end else begin
                  ovf_err <= 1'b1;
                  err_cnt <= err_cnt + 16'd1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
